alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//   Parametrised, two-stage pipelined successor to the 32-bit combinational ALU. It carries the same
//   3-bit command set and flag semantics, but WIDTH is configurable. Input and output each use a
//   valid/ready handshake with full backpressure. It also keeps a sticky overflow flag and a count of
//   completed operations. It sits between the operand/register-read stage and writeback.
// PARAMETERS
//   WIDTH   32  operand/result width in bits (>=2)
//   CNT_W   16  width of op_count
// PORTS
//   clk             input   1      rising-edge clock (single clock domain)
//   reset           input   1      asynchronous, active-high reset
//   in_valid        input   1      operand_a/operand_b/command valid
//   in_ready        output  1      block accepts input this cycle
//   operand_a       input   WIDTH  first operand
//   operand_b       input   WIDTH  second operand
//   command         input   3      000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR
//   out_valid       output  1      result/flags valid
//   out_ready       input   1      consumer accepts output this cycle
//   result          output  WIDTH  operation result
//   carryout        output  1      ADD carry out; SUB borrow (1 iff A<B unsigned); 0 otherwise
//   zero            output  1      1 iff result == 0 (all commands)
//   overflow        output  1      signed overflow for ADD/SUB; 0 otherwise
//   clear_sticky    input   1      synchronous clear of sticky_overflow
//   sticky_overflow output  1      set by any output transfer with overflow=1
//   op_count        output  CNT_W  number of output transfers, mod 2^CNT_W
// BEHAVIOUR
//   - Reset (async assert, sync release): s1_valid=0, s2_valid=0, in_ready=1, out_valid=0;
//     result=0, carryout=0, overflow=0, zero=1, sticky_overflow=0, op_count=0.
//   - Transfers: input transfer = in_valid&in_ready; output transfer = out_valid&out_ready.
//   - Stage 1 registers operands and command. Stage 2 registers the computed result and flags.
//   - adv2 = !s2_valid | out_ready. adv1 = !s1_valid | adv2. in_ready = adv1 (combinational, no bubble).
//   - Latency: an input accepted in cycle N appears with out_valid=1 in cycle N+2 if unstalled.
//   - Throughput is 1 operation/cycle while out_ready=1.
//   - Stall: while out_valid & !out_ready, result and all flags hold stable and stage 2 does not change.
//     Stage 1 accepts input only if it is empty.
//   - Ordering: results leave in acceptance order. There is no drop and no duplication.
//   - Arithmetic:
//     - ADD: {carryout,result} = A+B.
//     - SUB: result = A-B (mod 2^WIDTH).
//     - overflow = signed overflow of the WIDTH-bit op.
//     - SLT: result = {WIDTH-1 zeros, (A<B signed)}, computed as sign(A-B) XOR overflow(A-B).
//       Its carryout and overflow are forced to 0.
//     - Logic ops are bitwise. Their carryout and overflow are 0.
//   - sticky_overflow: set on an output transfer with overflow=1; cleared by clear_sticky.
//     If set and clear occur in the same cycle, set wins.
//   - op_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
//   - in_valid with in_ready=0 has no effect. The source holds its inputs until it sees in_ready.
//   - Reset asserted mid-operation discards all in-flight ops immediately. No partial output is produced.
// STRUCTURE
//   - alu_pkg: command encoding localparams (ALU_ADD..ALU_OR) and the default WIDTH.
//     Shared with the decoder and the testbench.
//   - Sub-module alu_core #(WIDTH): purely combinational and unregistered.
//     Computes result/carryout/overflow/zero from A, B and command. It is instantiated between stage 1 and stage 2.
//   - alu_pipe holds the pipeline registers, handshake logic, sticky flag and counter.
// TESTING
//   1. ADD, WIDTH=32, out_ready=1: 0+0 -> result=0, zero=1, carry=0, ovf=0, out_valid 2 cycles after accept.
//   2. SUB 300-100 -> 200, carry=0, ovf=0, zero=0.
//      SUB 100-300 -> 0xFFFFFF38, carry=1.
//      ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1, sticky=1.
//   3. Logic: A=0x11C, B=0x1FF. Required results:
//      XOR -> 0xE3; AND -> 0x11C; NAND -> 0xFFFFFEE3; OR -> 0x1FF; NOR -> 0xFFFFFE00.
//      SLT -5<3 -> 1; SLT 200<100 -> 0.
//   4. Backpressure: stream 8 ADDs (i+i) while out_ready toggles 1,0,0,1,...
//      Required: results 0,2,..,14 in order, none lost, outputs stable while stalled,
//      in_ready=0 only while both stages are full and out_ready=0.
//   5. Counters, CNT_W=3: 9 output transfers -> op_count=1.
//      clear_sticky coincident with an overflowing transfer -> sticky stays 1.
//   6. Reset with 2 ops in flight -> out_valid=0, op_count=0, zero=1 immediately.
//      First post-reset op is output correctly. Repeat case 2 with WIDTH=8 (0x7F+1 -> 0x80, ovf=1).

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: command encodings and default width
// shared by the ALU datapath, pipeline and bench
package alu_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_NAND = 3'b101;
  localparam logic [2:0] ALU_NOR  = 3'b110;
  localparam logic [2:0] ALU_OR   = 3'b111;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath
// result and flags from a, b and command
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       command,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           add_ovf;
  logic           sub_ovf;
  logic           slt;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                   (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                   (diff[WIDTH-1] != a[WIDTH-1]);

  // signed less-than from the subtraction's sign and overflow
  assign slt = diff[WIDTH-1] ^ sub_ovf;

  // command decode; arithmetic flags only for ADD/SUB
  always_comb begin
    result   = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    unique case (command)
      ALU_ADD: begin
        result   = sum[WIDTH-1:0];
        carryout = sum[WIDTH];
        overflow = add_ovf;
      end
      ALU_SUB: begin
        result   = diff[WIDTH-1:0];
        carryout = diff[WIDTH];
        overflow = sub_ovf;
      end
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
      ALU_AND:  result = a & b;
      ALU_NAND: result = ~(a & b);
      ALU_NOR:  result = ~(a | b);
      ALU_OR:   result = a | b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU
// valid/ready on both sides, sticky overflow, op counter
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [2:0]       command,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow,
  input  logic             clear_sticky,
  output logic             sticky_overflow,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_cmd;
  logic             s2_valid;
  logic             adv1;
  logic             adv2;
  logic             out_xfer;

  logic [WIDTH-1:0] c_result;
  logic             c_carry;
  logic             c_ovf;
  logic             c_zero;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid && out_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (s1_a),
    .b        (s1_b),
    .command  (s1_cmd),
    .result   (c_result),
    .carryout (c_carry),
    .overflow (c_ovf),
    .zero     (c_zero)
  );

  // stage 1: capture operands whenever the stage can move
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cmd   <= ALU_ADD;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= operand_a;
        s1_b   <= operand_b;
        s1_cmd <= command;
      end
    end
  end

  // stage 2: register result and flags; hold while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result   <= c_result;
        carryout <= c_carry;
        overflow <= c_ovf;
        zero     <= c_zero;
      end
    end
  end

  // sticky overflow: a set on transfer beats a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sticky_overflow <= 1'b0;
    else if (out_xfer && overflow)
      sticky_overflow <= 1'b1;
    else if (clear_sticky)
      sticky_overflow <= 1'b0;
  end

  // completed-operation counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      op_count <= '0;
    else if (out_xfer)
      op_count <= op_count + 1'b1;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed bench for alu_pipe
// 32-bit/CNT_W=3 and 8-bit instances share control
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        clear_sticky = 1'b0;
  logic [2:0]  command = ALU_ADD;

  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        carryout;
  logic        zero;
  logic        overflow;
  logic        sticky_overflow;
  logic [2:0]  op_count;

  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        in_ready8;
  logic        out_valid8;
  logic [7:0]  result8;
  logic        carry8;
  logic        zero8;
  logic        ovf8;
  logic        sticky8;
  logic [15:0] count8;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b),
    .command(command),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout),
    .zero(zero), .overflow(overflow),
    .clear_sticky(clear_sticky),
    .sticky_overflow(sticky_overflow),
    .op_count(op_count)
  );

  alu_pipe #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready8),
    .operand_a(a8), .operand_b(b8),
    .command(command),
    .out_valid(out_valid8), .out_ready(out_ready),
    .result(result8), .carryout(carry8),
    .zero(zero8), .overflow(ovf8),
    .clear_sticky(clear_sticky),
    .sticky_overflow(sticky8),
    .op_count(count8)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    else
      n_pass++;
  endtask

  // issue one op with out_ready=1 and check it two edges later
  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [2:0]  cmd,
                        input logic [31:0] er,
                        input logic ec, eo, ez,
                        input string tag);
    operand_a = a;
    operand_b = b;
    command   = cmd;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check({tag, " lat1"}, 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check({tag, " valid"}, 64'(out_valid), 64'(1));
    check({tag, " res"}, 64'(result), 64'(er));
    check({tag, " carry"}, 64'(carryout), 64'(ec));
    check({tag, " ovf"}, 64'(overflow), 64'(eo));
    check({tag, " zero"}, 64'(zero), 64'(ez));
  endtask

  task automatic run_op8(input logic [7:0] a,
                         input logic [7:0] b,
                         input logic [2:0] cmd,
                         input logic [7:0] er,
                         input logic ec, eo, ez,
                         input string tag);
    a8       = a;
    b8       = b;
    command  = cmd;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " valid"}, 64'(out_valid8), 64'(1));
    check({tag, " res"}, 64'(result8), 64'(er));
    check({tag, " carry"}, 64'(carry8), 64'(ec));
    check({tag, " ovf"}, 64'(ovf8), 64'(eo));
    check({tag, " zero"}, 64'(zero8), 64'(ez));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int  sent, recv, cyc;
    bit  m1, m2, n1, n2, a1, a2;
    bit  stalled;
    logic [31:0] prev;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst in_ready", 64'(in_ready), 64'(1));
    check("rst result", 64'(result), 64'(0));
    check("rst zero", 64'(zero), 64'(1));
    check("rst carry", 64'(carryout), 64'(0));
    check("rst ovf", 64'(overflow), 64'(0));
    check("rst sticky", 64'(sticky_overflow), 64'(0));
    check("rst count", 64'(op_count), 64'(0));

    // arithmetic
    run_op(0, 0, ALU_ADD, 0, 0, 0, 1, "add0");
    run_op(300, 100, ALU_SUB, 200, 0, 0, 0, "sub300");
    run_op(100, 300, ALU_SUB, 32'hFFFFFF38, 1, 0, 0,
           "sub100");
    run_op(32'h7FFFFFFF, 1, ALU_ADD, 32'h80000000,
           0, 1, 0, "addovf");
    @(posedge clk);
    #1;
    check("sticky set", 64'(sticky_overflow), 64'(1));

    // logic and compare
    run_op(32'h11C, 32'h1FF, ALU_XOR, 32'hE3, 0, 0, 0,
           "xor");
    run_op(32'h11C, 32'h1FF, ALU_AND, 32'h11C, 0, 0, 0,
           "and");
    run_op(32'h11C, 32'h1FF, ALU_NAND, 32'hFFFFFEE3,
           0, 0, 0, "nand");
    run_op(32'h11C, 32'h1FF, ALU_OR, 32'h1FF, 0, 0, 0,
           "or");
    run_op(32'h11C, 32'h1FF, ALU_NOR, 32'hFFFFFE00,
           0, 0, 0, "nor");
    run_op(32'hFFFFFFFB, 3, ALU_SLT, 1, 0, 0, 0, "slt-5");
    run_op(200, 100, ALU_SLT, 0, 0, 0, 1, "slt200");
    run_op(32'h80000000, 1, ALU_SLT, 1, 0, 0, 0,
           "sltmin");
    @(posedge clk);
    #1;

    // backpressure stream of 8 ADDs, out_ready 1,0,0,...
    sent = 0;
    recv = 0;
    cyc  = 0;
    m1 = 0;
    m2 = 0;
    stalled = 0;
    prev = result;
    while (recv < 8 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 8);
      operand_a = 32'(sent);
      operand_b = 32'(sent);
      command   = ALU_ADD;
      #1;
      check("bp in_ready", 64'(in_ready),
            64'(!(m1 && m2 && !out_ready)));
      check("bp out_valid", 64'(out_valid), 64'(m2));
      if (stalled)
        check("bp hold", 64'(result), 64'(prev));
      if (out_valid && out_ready) begin
        check("bp data", 64'(result), 64'(2 * recv));
        recv++;
      end
      stalled = out_valid && !out_ready;
      prev = result;
      a2 = !m2 || out_ready;
      a1 = !m1 || a2;
      n2 = a2 ? m1 : m2;
      n1 = a1 ? in_valid : m1;
      if (in_valid && in_ready)
        sent++;
      m1 = n1;
      m2 = n2;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp received", 64'(recv), 64'(8));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // counter wrap and set-beats-clear
    do_reset();
    for (int i = 0; i < 8; i++)
      run_op(1, 1, ALU_ADD, 2, 0, 0, 0, "cnt");
    run_op(32'h7FFFFFFF, 1, ALU_ADD, 32'h80000000,
           0, 1, 0, "cntovf");
    clear_sticky = 1'b1;
    @(posedge clk);
    #1 clear_sticky = 1'b0;
    check("count wrap", 64'(op_count), 64'(1));
    check("set beats clr", 64'(sticky_overflow), 64'(1));
    clear_sticky = 1'b1;
    @(posedge clk);
    #1 clear_sticky = 1'b0;
    check("clr sticky", 64'(sticky_overflow), 64'(0));

    // reset with two ops in flight
    out_ready = 1'b0;
    operand_a = 32'd9;
    operand_b = 32'd9;
    command   = ALU_ADD;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 operand_a = 32'd4;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("pre-rst valid", 64'(out_valid), 64'(1));
    reset = 1'b1;
    #1;
    check("mid-rst valid", 64'(out_valid), 64'(0));
    check("mid-rst count", 64'(op_count), 64'(0));
    check("mid-rst zero", 64'(zero), 64'(1));
    check("mid-rst result", 64'(result), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst valid", 64'(out_valid), 64'(0));
    run_op(5, 7, ALU_ADD, 12, 0, 0, 0, "post-rst");
    @(posedge clk);
    #1;

    // 8-bit instance
    run_op8(8'h7F, 8'h01, ALU_ADD, 8'h80, 0, 1, 0, "w8add");
    @(posedge clk);
    #1;
    check("w8 sticky", 64'(sticky8), 64'(1));
    run_op8(8'h64, 8'hC8, ALU_SUB, 8'h9C, 1, 1, 0, "w8sub");
    run_op8(8'hFF, 8'h01, ALU_ADD, 8'h00, 1, 0, 1, "w8wrap");
    run_op8(8'hFB, 8'h03, ALU_SLT, 8'h01, 0, 0, 0, "w8slt");
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
